// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
//   Drives a 4-digit multiplexed seven-segment display from three BCD digits.
//   A new digit set is taken through a valid/ready handshake into a pending
//   register and copied to the display registers only at a frame wrap, so one
//   frame never mixes old and new digits. Each digit slot starts with a guard
//   interval with every anode off, which prevents ghosting. Leading zeros are
//   blanked, and non-BCD digits (10..15) are shown as a dash.
// Ports
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   digit-set handshake
//   hundreds/tens/ones  BCD digits offered with in_valid
//   an[3:0]             digit enables, an[0] = ones (rightmost)
//   seg[6:0]            {g,f,e,d,c,b,a}
//   dp                  decimal point, held inactive
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [3:0]    AN_OFF    = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0]    SEG_OFF   = ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
  } digits_t;

  // Active-high segment pattern; anything outside 0..9 is a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  digits_t       disp, pend;
  logic          pend_full;

  logic slot_end, frame_wrap;
  assign slot_end   = (cnt == CNT_MAX);
  assign frame_wrap = slot_end && (idx == 2'd3);

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Handshake. Accept needs an empty pending register and transfer needs a
  // full one, so the two never collide; an accept on the wrap cycle simply
  // waits for the following wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp      <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
    end else begin
      if (frame_wrap && pend_full) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end
      if (in_valid && !pend_full) begin
        pend      <= '{h: hundreds, t: tens, o: ones};
        pend_full <= 1'b1;
      end
    end
  end

  assign in_ready = !pend_full;

  // Slot content. Blanking looks at the raw digit value, so a dash is never
  // blanked.
  logic [3:0] cur;
  logic       blank;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;

  always_comb begin
    cur   = '0;
    blank = 1'b1;
    case (idx)
      2'd0: begin cur = disp.o; blank = 1'b0; end
      2'd1: begin cur = disp.t; blank = (disp.h == 4'd0) && (disp.t == 4'd0); end
      2'd2: begin cur = disp.h; blank = (disp.h == 4'd0); end
      default: begin cur = '0; blank = 1'b1; end
    endcase

    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    if (!(cnt < CNT_GUARD) && !blank) begin
      an_nxt  = 4'(4'b0001 << idx) ^ {4{ACTIVE_LOW}};
      seg_nxt = decode(cur) ^ {7{ACTIVE_LOW}};
    end
  end

  // Registered drive: one clock behind (idx,cnt), glitch-free, and forced
  // dark asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

  assign dp = ACTIVE_LOW ? 1'b1 : 1'b0;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver
//   Self-checking bench for sevenseg_scan_driver (REFRESH_DIV=8, GUARD=2,
//   active-low). A reference model tracks absolute cycle count since reset
//   release and derives slot/position arithmetically; each cycle an, seg, dp
//   and in_ready are compared with it. Directed frames are also compared with
//   literal segment codes.
module tb_sevenseg_scan_driver;
  localparam int RD = 8;
  localparam int GD = 2;
  localparam int FR = 4 * RD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] hundreds = '0, tens = '0, ones = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  sevenseg_scan_driver #(.REFRESH_DIV(RD), .GUARD(GD), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Active-high glyphs; 10..15 are dashes.
  int glyph[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                    'h7F, 'h6F, 'h40, 'h40, 'h40, 'h40, 'h40, 'h40};

  // Model state: digits indexed 0=ones, 1=tens, 2=hundreds.
  int m_cyc;
  int m_dig[3];
  int m_pend[3];
  bit m_full;
  int e_an, e_seg;

  function automatic void m_reset();
    m_cyc  = 0;
    m_dig  = '{0, 0, 0};
    m_pend = '{0, 0, 0};
    m_full = 1'b0;
    e_an   = 'hF;
    e_seg  = 'h7F;
  endfunction

  // One clock edge of the model; expected outputs come from the pre-edge state.
  function automatic void m_edge(input bit v, input int h, input int t, input int o);
    int  slot, pos, val;
    bit  dark;
    slot = (m_cyc / RD) % 4;
    pos  = m_cyc % RD;
    val  = (slot == 3) ? 0 : m_dig[slot];
    dark = (pos < GD) || (slot == 3) ||
           (slot == 2 && m_dig[2] == 0) ||
           (slot == 1 && m_dig[2] == 0 && m_dig[1] == 0);
    e_an  = dark ? 'hF  : ('hF  & ~(1 << slot));
    e_seg = dark ? 'h7F : ('h7F & ~glyph[val]);
    if ((m_cyc % FR) == FR - 1 && m_full) begin
      m_dig  = m_pend;
      m_full = 1'b0;
    end else if (v && !m_full) begin
      m_pend = '{o, t, h};
      m_full = 1'b1;
    end
    m_cyc++;
  endfunction

  bit [3:0]   cap_lit;
  logic [6:0] cap_seg[4];

  task automatic step(input bit v, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    in_valid = v; hundreds = h; tens = t; ones = o;
    @(posedge clk);
    m_edge(v, int'(h), int'(t), int'(o));
    @(negedge clk);
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("dp", dp, 1);
    chk("in_ready", in_ready, !m_full);
    for (int i = 0; i < 4; i++)
      if (an[i] == 1'b0) begin
        cap_lit[i] = 1'b1;
        cap_seg[i] = seg;
      end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'd0, 4'd0, 4'd0);
  endtask

  // Hold in_valid until the block takes the value (bounded).
  task automatic offer(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    bit acc = 1'b0;
    for (int k = 0; k < 4 * FR && !acc; k++) begin
      acc = !m_full;
      step(1'b1, h, t, o);
    end
    in_valid = 1'b0;
    chk("offer_accepted", acc, 1);
  endtask

  task automatic align();
    for (int k = 0; k < FR && (m_cyc % FR) != 0; k++) idle(1);
  endtask

  task automatic cap_clear();
    cap_lit = '0;
    for (int i = 0; i < 4; i++) cap_seg[i] = 'x;
  endtask

  task automatic capture();
    cap_clear();
    idle(FR);
  endtask

  // Expected segment per slot; -1 means the slot stays dark.
  task automatic check4(input string tag, input int s0, input int s1, input int s2, input int s3);
    int s[4];
    s = '{s0, s1, s2, s3};
    for (int i = 0; i < 4; i++) begin
      if (s[i] < 0) chk($sformatf("%s_dark%0d", tag, i), cap_lit[i], 0);
      else begin
        chk($sformatf("%s_lit%0d", tag, i), cap_lit[i], 1);
        chk($sformatf("%s_seg%0d", tag, i), cap_seg[i], s[i]);
      end
    end
  endtask

  function automatic logic [3:0] rnd_dig();
    return ($urandom % 4 == 0) ? 4'd0 : 4'($urandom % 16);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    cap_clear();
    repeat (3) @(negedge clk);
    chk("rst_an", an, 'hF);
    chk("rst_seg", seg, 'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;

    // Power-up frame shows a lone "0".
    capture();
    check4("boot", 'h40, -1, -1, -1);

    // Mid-frame accept, shown after the wrap.
    idle(10);
    offer(4'd2, 4'd4, 4'd7);
    align();
    capture();
    check4("v247", 'h78, 'h19, 'h24, -1);

    // Leading-zero blanking and dash handling.
    offer(4'd0, 4'd0, 4'd5);  align(); capture(); check4("v005", 'h12, -1, -1, -1);
    offer(4'd1, 4'd0, 4'd0);  align(); capture(); check4("v100", 'h40, 'h40, 'h79, -1);
    offer(4'd0, 4'd3, 4'd0);  align(); capture(); check4("v030", 'h40, 'h30, -1, -1);
    offer(4'd0, 4'd12, 4'd3); align(); capture(); check4("v0c3", 'h30, 'h3F, -1, -1);

    // Backpressure: 9,9,9 waits behind 1,1,1.
    offer(4'd1, 4'd1, 4'd1);
    cap_clear();
    offer(4'd9, 4'd9, 4'd9);
    check4("bp_old", 'h30, 'h3F, -1, -1);
    cap_clear();
    align();
    check4("bp_111", 'h79, 'h79, 'h79, -1);
    capture();
    check4("bp_999", 'h10, 'h10, 'h10, -1);

    // Randomized traffic.
    repeat (1500) step(($urandom % 3) == 0, rnd_dig(), rnd_dig(), rnd_dig());
    in_valid = 1'b0;

    // Reset in the hundreds slot with a value pending.
    offer(4'd1, 4'd1, 4'd1);
    align();
    offer(4'd5, 4'd5, 4'd5);
    for (int k = 0; k < FR && (m_cyc % FR) != 2 * RD + 5; k++) idle(1);
    chk("pre_rst_an", an, 'hB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_an", an, 'hF);
    chk("async_seg", seg, 'h7F);
    chk("async_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    m_reset();
    rst_n = 1'b1;
    capture();
    check4("post_rst0", 'h40, -1, -1, -1);
    capture();
    check4("post_rst1", 'h40, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Downstream consumer of the binary-to-BCD converter. Takes the hundreds/tens/ones BCD digits and drives a 4-digit multiplexed seven-segment display of the kind on the Spartan-3 starter board.
- Captures a new value through a valid/ready handshake and applies it only at frame boundaries, so a displayed frame never mixes old and new digits.
- Scans the digits with anti-ghosting guard time, blanks leading zeros, and flags invalid BCD digits.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot (>= GUARD+2).
- GUARD, 16: cycles at the start of each slot during which all anodes are off.
- ACTIVE_LOW, 1: 1 = anodes and segments active-low; 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  new digit set offered.
- in_ready  out  1  block can accept a digit set.
- hundreds  in  4  BCD hundreds digit.
- tens  in  4  BCD tens digit.
- ones  in  4  BCD ones digit.
- an  out  4  digit enables; an[0] = rightmost (ones) digit.
- seg  out  7  {g,f,e,d,c,b,a}.
- dp  out  1  decimal point; always inactive.

Behaviour:
- Reset (async assert, sync release):
  - an and seg inactive (ACTIVE_LOW=1: an=4'b1111, seg=7'h7F); dp inactive.
  - Slot counter cnt=0, digit index idx=0.
  - Display registers = 0,0,0; pending register empty; in_ready=1.
- Scan:
  - cnt counts 0..REFRESH_DIV-1 and wraps.
  - When cnt=REFRESH_DIV-1, idx advances 0->1->2->3->0.
  - Frame wrap is the cycle with idx=3 and cnt=REFRESH_DIV-1.
- Handshake:
  - Accept occurs on a cycle with in_valid=1 and in_ready=1. The three digits are captured into pending, and in_ready goes 0 the next cycle.
  - On frame wrap, a full pending register moves into the display registers and pending becomes empty; in_ready returns to 1 the next cycle.
  - in_valid while in_ready=0 is ignored; the source must hold it.
  - Accept on the frame-wrap cycle itself: pending was empty, so the value goes to pending and displays after the following frame wrap.
- Digit content per idx:
  - idx0: ones, always shown.
  - idx1: tens; blanked if hundreds==0 and tens==0.
  - idx2: hundreds; blanked if hundreds==0.
  - idx3: always blanked.
  - Blanked means the anode stays inactive for the whole slot.
- Decode (values given active-high; complement when ACTIVE_LOW=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any digit value 10..15 shows a dash (40) and is never blanked. Blanking tests use the raw value ==0.
- Guard: while cnt<GUARD, all anodes are inactive and seg is inactive.
- Otherwise exactly one anode (an[idx]) is active, unless the digit is blanked.
- an and seg are registered and lag (idx,cnt) by exactly one clock.
- No glitches: an and seg change only on clk edges.
- Reset mid-operation: an and seg go inactive immediately (asynchronously); pending is discarded and the display returns to 0.

Test Plan:
Bench parameters: REFRESH_DIV=8, GUARD=2, ACTIVE_LOW=1.
1. Reset and release -> in_ready=1; an=1111 during guard cycles. Ones slot shows an=1110, seg=40 ("0"). Slots 1, 2 and 3 are fully dark (an=1111 throughout).
2. Offer 2,4,7 mid-frame -> accepted; in_ready=0 until the cycle after frame wrap. Then ones an=1110 seg=78, tens an=1101 seg=19, hundreds an=1011 seg=24, slot 3 an=1111.
3. Leading zeros:
   - 0,0,5 -> only the ones slot lit, seg=12.
   - 1,0,0 -> tens seg=40 and hundreds seg=79 both lit.
   - 0,3,0 -> tens seg=30, hundreds dark.
4. Invalid BCD: 0,12,3 -> tens slot lit with seg=3F (dash) and the hundreds slot dark; ones seg=30.
5. Backpressure: accept 1,1,1, then hold in_valid with 9,9,9 before the wrap -> 9,9,9 is refused until in_ready=1. Display sequence: one frame of the old value, then 1,1,1 (seg=79), then 9,9,9 (seg=10) one frame later.
6. Drop rst_n during idx=2 with a pending value -> an=1111 the same cycle without any clock edge. After release, the display shows 0 and the pending value is never shown.
